wide_add_seq: RTL

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq_pkg.sv | 12 +
 rtl/add16_slice.sv | 23 ++
 rtl/wide_add_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the slice-serial wide adder: controller states and slice width.
package wide_add_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add16_slice.sv
// 16-bit ripple-carry adder; the one shared arithmetic unit of the wide adder.
module add16_slice
    import wide_add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    always_comb begin : ripple
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Slice-serial W-bit adder/subtractor: one 16-bit slice per RUN cycle through a shared adder.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int SLICES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        sub,
    input  logic [SLICE_W*SLICES-1:0]   a,
    input  logic [SLICE_W*SLICES-1:0]   b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [SLICE_W*SLICES-1:0]   sum,
    output logic                        cout,
    output logic                        ovf
);

    localparam int W     = SLICE_W * SLICES;
    localparam int IDX_W = $clog2(SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry;

    logic [SLICE_W-1:0] slice_a, slice_b, slice_s;
    logic               slice_co;
    logic               accept, step, finish, cancel;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        cancel    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (idx == LAST_IDX) begin
                        finish    = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    assign slice_a = a_q[idx*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx*SLICE_W +: SLICE_W];

    add16_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // Subtraction is folded in at capture time: B is stored inverted and the carry preloaded with 1.
    // NOTE: the operand registers are small flops, not a RAM, so they take the async reset like all other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (cancel) begin
            idx  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (step) begin
            sum[idx*SLICE_W +: SLICE_W] <= slice_s;
            carry <= slice_co;
            idx   <= idx + 1'b1;
            if (finish) begin
                cout <= slice_co;
                ovf  <= (a_q[W-1] == b_q[W-1]) && (slice_s[SLICE_W-1] != a_q[W-1]);
            end
        end
    end

endmodule
